// File: rtl/mips_hazard_pkg.sv
// Shared types, stage-timing constants and the RAW compare helper for the
// hazard/stall controller.
package mips_hazard_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] stage_t;

  // Tuse: stages until the ID-stage operand is consumed.
  localparam stage_t TUSE_ID   = 2'd0;
  localparam stage_t TUSE_EX   = 2'd1;
  localparam stage_t TUSE_MEM  = 2'd2;
  localparam stage_t TUSE_NONE = 2'd3;

  // Tnew: cycles until a producer's result can be forwarded.
  localparam stage_t TNEW_NOW = 2'd0;
  localparam stage_t TNEW_ONE = 2'd1;
  localparam stage_t TNEW_TWO = 2'd2;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  // Individual stall reasons, kept together so they can be probed as one.
  typedef struct packed {
    logic rs_haz;
    logic rt_haz;
    logic md_haz;
  } haz_t;

  function automatic logic raw_hazard(
    input reg_idx_t src,
    input stage_t   tuse,
    input reg_idx_t dst_e,
    input stage_t   tnew_e,
    input reg_idx_t dst_m,
    input stage_t   tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = (src == dst_e) && (tnew_e > tuse);
    hit_m = (src == dst_m) && (tnew_m > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage operand info, EX/MEM producer info and the resulting pipeline
// controls, bundled between the pipeline and the hazard controller.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  import mips_hazard_pkg::*;

  reg_idx_t         rs_d;
  reg_idx_t         rt_d;
  stage_t           tuse_rs_d;
  stage_t           tuse_rt_d;
  logic             md_use_d;
  reg_idx_t         dst_e;
  stage_t           tnew_e;
  reg_idx_t         dst_m;
  stage_t           tnew_m;
  logic             md_start_e;
  logic             md_div_e;

  logic             stall;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: supplies stage info, consumes the controls.
  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
    output dst_e, tnew_e, dst_m, tnew_m, md_start_e, md_div_e,
    input  stall, pc_en, ifid_en, idex_flush, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_use_d,
    input  dst_e, tnew_e, dst_m, tnew_m, md_start_e, md_div_e,
    output stall, pc_en, ifid_en, idex_flush, md_busy, md_done, stall_cnt
  );

endinterface

// File: rtl/md_busy_counter.sv
// Mult/div occupancy countdown: loads the unit latency on start, counts down
// to zero, and flags busy plus a one-cycle done pulse on the 1->0 step.
module md_busy_counter
  import mips_hazard_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A start always reloads, so a start while busy restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy  <= (cnt_d != '0);
      done  <= !start && (cnt_q == CW'(1));
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: Tuse/Tnew RAW detection against EX and MEM,
// mult/div occupancy interlock, and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_ctrl_if.slave hif
);

  haz_t             haz;
  logic             stall;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt_q;

  always_comb begin
    haz.rs_haz = raw_hazard(hif.rs_d, hif.tuse_rs_d, hif.dst_e, hif.tnew_e,
                            hif.dst_m, hif.tnew_m);
    haz.rt_haz = raw_hazard(hif.rt_d, hif.tuse_rt_d, hif.dst_e, hif.tnew_e,
                            hif.dst_m, hif.tnew_m);
    // A unit start in EX already claims HI/LO for the next ID consumer.
    haz.md_haz = hif.md_use_d && (md_busy || hif.md_start_e);
  end

  assign stall = |haz;

  md_busy_counter #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (hif.md_start_e),
    .is_div(hif.md_div_e),
    .busy  (md_busy),
    .done  (md_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hif.stall      = stall;
  assign hif.pc_en      = ~stall;
  assign hif.ifid_en    = ~stall;
  assign hif.idex_flush = stall;
  assign hif.md_busy    = md_busy;
  assign hif.md_done    = md_done;
  assign hif.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: RAW cases, register 0 / unused
// operands, div occupancy, restart, mid-run reset and counter saturation.
module tb_hazard_stall_ctrl;
  import mips_hazard_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_stall_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10),
    .CNT_W   (CNT_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hif  (hif)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.rs_d       = 5'd0;
    hif.rt_d       = 5'd0;
    hif.tuse_rs_d  = TUSE_NONE;
    hif.tuse_rt_d  = TUSE_NONE;
    hif.md_use_d   = 1'b0;
    hif.dst_e      = 5'd0;
    hif.tnew_e     = TNEW_NOW;
    hif.dst_m      = 5'd0;
    hif.tnew_m     = TNEW_NOW;
    hif.md_start_e = 1'b0;
    hif.md_div_e   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic exp_stall);
    chk({tag, "_stall"}, 32'(hif.stall), 32'(exp_stall));
    chk({tag, "_pc_en"}, 32'(hif.pc_en), 32'(!exp_stall));
    chk({tag, "_ifid_en"}, 32'(hif.ifid_en), 32'(!exp_stall));
    chk({tag, "_idex_flush"}, 32'(hif.idex_flush), 32'(exp_stall));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(hif.md_busy), 0);
    chk("rst_done", 32'(hif.md_done), 0);
    chk("rst_cnt", 32'(hif.stall_cnt), 0);
    chk_ctrl("rst", 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // No hazard
    hif.rs_d = 5'd5; hif.tuse_rs_d = TUSE_ID;
    hif.dst_e = 5'd6; hif.tnew_e = TNEW_TWO;
    hif.dst_m = 5'd7; hif.tnew_m = TNEW_ONE;
    #1 chk_ctrl("nohaz", 1'b0);
    tick();
    chk("nohaz_cnt", 32'(hif.stall_cnt), 0);

    // Load-use: EX producer two cycles out, consumer needs it in EX
    idle();
    hif.rs_d = 5'd8; hif.tuse_rs_d = TUSE_EX;
    hif.dst_e = 5'd8; hif.tnew_e = TNEW_TWO;
    #1 chk_ctrl("loaduse", 1'b1);
    tick();
    hif.dst_e = 5'd0; hif.tnew_e = TNEW_NOW;
    hif.dst_m = 5'd8; hif.tnew_m = TNEW_ONE;
    #1 chk_ctrl("loaduse_next", 1'b0);
    chk("loaduse_cnt", 32'(hif.stall_cnt), 1);

    // MEM producer with ID-stage use, then EX rt match that is just in time
    hif.tuse_rs_d = TUSE_ID;
    #1 chk("mem_rs_stall", 32'(hif.stall), 1);
    idle();
    hif.rt_d = 5'd12; hif.tuse_rt_d = TUSE_ID;
    hif.dst_e = 5'd12; hif.tnew_e = TNEW_ONE;
    #1 chk("ex_rt_stall", 32'(hif.stall), 1);
    hif.tuse_rt_d = TUSE_EX;
    #1 chk("ex_rt_intime", 32'(hif.stall), 0);

    // Register 0 and unused operands never hazard
    idle();
    hif.rs_d = 5'd0; hif.tuse_rs_d = TUSE_ID;
    hif.dst_e = 5'd0; hif.tnew_e = TNEW_TWO;
    #1 chk("reg0", 32'(hif.stall), 0);
    hif.rt_d = 5'd9; hif.tuse_rt_d = TUSE_NONE;
    hif.dst_m = 5'd9; hif.tnew_m = TNEW_ONE;
    #1 chk("unused_rt", 32'(hif.stall), 0);
    tick();
    chk("reg0_cnt", 32'(hif.stall_cnt), 1);

    // Async reset clears the counter between segments
    idle();
    rst_n = 1'b0;
    #1 chk("rst2_cnt", 32'(hif.stall_cnt), 0);
    #1 rst_n = 1'b1;
    tick();

    // Div occupancy with an md consumer waiting in ID throughout
    hif.md_use_d = 1'b1; hif.md_start_e = 1'b1; hif.md_div_e = 1'b1;
    #1 chk("div_start_stall", 32'(hif.stall), 1);
    chk("div_start_busy", 32'(hif.md_busy), 0);
    tick();
    hif.md_start_e = 1'b0; hif.md_div_e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("div_busy%0d", i), 32'(hif.md_busy), 1);
      chk($sformatf("div_done%0d", i), 32'(hif.md_done), 0);
      chk($sformatf("div_stall%0d", i), 32'(hif.stall), 1);
      tick();
    end
    chk("div_end_busy", 32'(hif.md_busy), 0);
    chk("div_end_done", 32'(hif.md_done), 1);
    chk("div_end_stall", 32'(hif.stall), 0);
    chk("div_cnt", 32'(hif.stall_cnt), 11);
    tick();
    chk("div_done_pulse", 32'(hif.md_done), 0);
    chk("div_cnt_hold", 32'(hif.stall_cnt), 11);

    // Mult restarted by a div in busy cycle 3
    idle();
    hif.md_start_e = 1'b1;
    tick();
    hif.md_start_e = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mul_busy%0d", i), 32'(hif.md_busy), 1);
      chk($sformatf("mul_done%0d", i), 32'(hif.md_done), 0);
      if (i < 3) tick();
    end
    hif.md_start_e = 1'b1; hif.md_div_e = 1'b1;
    tick();
    hif.md_start_e = 1'b0; hif.md_div_e = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("restart_busy%0d", i), 32'(hif.md_busy), 1);
      chk($sformatf("restart_done%0d", i), 32'(hif.md_done), 0);
      tick();
    end
    chk("restart_end_busy", 32'(hif.md_busy), 0);
    chk("restart_end_done", 32'(hif.md_done), 1);
    tick();
    chk("restart_done_pulse", 32'(hif.md_done), 0);

    // Reset at busy cycle 4 aborts with no done
    hif.md_start_e = 1'b1; hif.md_div_e = 1'b1;
    tick();
    hif.md_start_e = 1'b0; hif.md_div_e = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_abort_busy", 32'(hif.md_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(hif.md_busy), 0);
    chk("abort_done", 32'(hif.md_done), 0);
    chk("abort_cnt", 32'(hif.stall_cnt), 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("post_abort_done%0d", i), 32'(hif.md_done), 0);
      chk($sformatf("post_abort_busy%0d", i), 32'(hif.md_busy), 0);
    end

    // Saturation: 20 stall cycles on a 4-bit counter
    hif.rs_d = 5'd3; hif.tuse_rs_d = TUSE_ID;
    hif.dst_e = 5'd3; hif.tnew_e = TNEW_ONE;
    #1 chk("sat_stall", 32'(hif.stall), 1);
    repeat (14) tick();
    chk("sat_cnt14", 32'(hif.stall_cnt), 14);
    tick();
    chk("sat_cnt15", 32'(hif.stall_cnt), 15);
    repeat (5) tick();
    chk("sat_cnt_hold", 32'(hif.stall_cnt), 15);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer of the stall/flush controls consumed by the pipeline registers: PC enable, IF/ID load enable, ID/EX flush.
- Detects RAW hazards with a Tuse/Tnew comparison between the ID-stage instruction and the producers in EX and MEM.
- Tracks multi-cycle mult/div occupancy with an internal countdown and stalls HI/LO consumers while it runs.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_LAT, 5, busy cycles after a mult start.
- DIV_LAT, 10, busy cycles after a div start.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rs_d  in  5  ID-stage rs index.
- rt_d  in  5  ID-stage rt index.
- tuse_rs_d  in  2  stages until rs is needed: 0 = ID, 1 = EX, 2 = MEM, 3 = unused.
- tuse_rt_d  in  2  same encoding, for rt.
- md_use_d  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- dst_e  in  5  EX-stage destination register, 0 = none.
- tnew_e  in  2  cycles until the EX result is forwardable (0..2).
- dst_m  in  5  MEM-stage destination register.
- tnew_m  in  2  cycles until the MEM result is forwardable (0..1).
- md_start_e  in  1  mult/div begins in EX this cycle.
- md_div_e  in  1  with md_start_e: 1 = div, 0 = mult.
- stall  out  1  combined stall this cycle.
- pc_en  out  1  PC register load enable (1 = load).
- ifid_en  out  1  IF/ID load enable (1 = load).
- idex_flush  out  1  ID/EX clear (1 = load zeros / bubble).
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse when the countdown reaches 0.
- stall_cnt  out  CNT_W  total stall cycles since reset.

Behaviour:
- Reset (rst_n=0, async): md_cnt=0, md_busy=0, md_done=0, stall_cnt=0. The combinational outputs then evaluate as stall=0, pc_en=1, ifid_en=1, idex_flush=0, provided md_start_e=0 and there is no register hazard.
- RAW hazard for rs, evaluated combinationally:
  - rs_d!=0 and tuse_rs_d!=3 and
  - either (rs_d==dst_e and tnew_e>tuse_rs_d) or (rs_d==dst_m and tnew_m>tuse_rs_d).
  - Identical rule for rt.
  - Register 0 never hazards.
  - A match in both EX and MEM is evaluated independently (OR).
- MD hazard: md_use_d and (md_busy or md_start_e).
- stall = rs_haz | rt_haz | md_haz.
- Control outputs are combinational from stall: pc_en=~stall, ifid_en=~stall, idex_flush=stall. There is no registered latency on these.
- mult/div countdown md_cnt (width clog2(DIV_LAT+1)):
  - md_start_e=1: load md_cnt=MULT_LAT or DIV_LAT per md_div_e. This takes priority over decrement, and a start while busy restarts the count.
  - Otherwise, if md_cnt!=0: decrement by 1.
- md_busy is registered and equals (md_cnt!=0) after the update. It rises the cycle after start and stays high for exactly LAT cycles.
- md_done is registered: 1 for the single cycle following the transition md_cnt 1->0, else 0. A restart on the same edge suppresses md_done.
- stall_cnt increments by 1 on each posedge where stall=1 and saturates at all-ones. There is no wrap.
- Reset asserted mid-operation aborts the countdown immediately. md_busy and md_done drop asynchronously; no md_done is generated.
- Inputs are assumed registered-stage values. The block holds no knowledge of instruction encoding.

Decomposition:
- Shared package mips_hazard_pkg:
  - TUSE_ID=0, TUSE_EX=1, TUSE_MEM=2, TUSE_NONE=3.
  - Tnew constants.
  - Default MULT_LAT and DIV_LAT.
- One sub-module, md_busy_counter: load/decrement countdown producing md_busy and md_done.
- RAW compare and stall combine stay in the top level.

Test Plan:
- No hazard: rs_d=5, dst_e=6, dst_m=7 -> stall=0, pc_en=1, ifid_en=1, idex_flush=0; stall_cnt stays 0.
- Load-use: dst_e=8, tnew_e=2, rs_d=8, tuse_rs_d=1 -> stall=1, idex_flush=1. Next cycle (dst_e=0, dst_m=8, tnew_m=1) -> stall=0. stall_cnt=1.
- Register-0 and unused operands: rs_d=0=dst_e, tnew_e=2, tuse=0 -> stall=0. rt_d=9=dst_m, tnew_m=1, tuse_rt_d=3 -> stall=0.
- Div occupancy:
  - md_start_e=1, md_div_e=1 -> md_busy=1 for exactly 10 cycles, then md_done=1 for 1 cycle.
  - md_use_d=1 throughout -> stall=1 during the start cycle plus 10 busy cycles (11 total). stall_cnt=11.
- Restart and reset:
  - mult start, then a div start at busy cycle 3 -> busy continues for 10 more cycles, with a single md_done.
  - Separately, rst_n=0 at busy cycle 4 -> md_busy=0 and md_done=0 immediately; stall_cnt=0.
- Saturation: force 2^CNT_W-1 stalls (CNT_W=4 in bench, 20 stall cycles) -> stall_cnt holds at 15.
